// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM QPI access blocks.
// Holds the QPI opcodes, the write-engine state encoding, the nibble-count
// constants of a QPI write frame and the pixel-to-byte address helper.
// No ports (package).
package psram_pkg;

  // QPI opcodes understood by the 64 Mbit PSRAM
  localparam logic [7:0] QPI_CMD_WRITE = 8'h38;
  localparam logic [7:0] QPI_CMD_READ  = 8'hEB;
  localparam logic [7:0] QPI_CMD_ENTER = 8'h35;
  localparam logic [7:0] QPI_CMD_EXIT  = 8'hF5;

  // Frame geometry in SIO nibbles
  localparam int CMD_NIBBLES     = 2;
  localparam int ADDR_NIBBLES    = 6;
  localparam int NIBBLES_PER_PIX = 4;
  localparam int MAX_BURST_PIX   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CSHI
  } psram_wr_state_t;

  // Pixels are halfwords, the PSRAM is byte addressed with a 24-bit address
  function automatic logic [23:0] psram_byte_addr(input logic [21:0] pix_addr);
    return {1'b0, pix_addr, 1'b0};
  endfunction

endpackage

// File: rtl/psram_wr_buf.sv
// Pixel staging buffer for the QPI write engine.
// Collects up to BURST_PIX contiguous pixels that share one BURST_PIX-aligned
// block, remembers the first pixel address, and offers a nibble read port
// used while the burst is shifted out on the SIO bus.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_wr_en            store i_wr_data at slot count (caller guarantees o_hit)
//   i_wr_addr          pixel address of the offered pixel (for the hit check)
//   i_wr_data          RGB565 pixel
//   i_clear            drop all buffered pixels
//   i_rd_idx           nibble index: [5:2] pixel slot, [1:0] nibble (0 = MSB)
//   o_count            number of buffered pixels
//   o_base             pixel address of slot 0
//   o_full, o_empty    count == BURST_PIX / count == 0
//   o_hit              offered pixel may join the buffer
//   o_rd_nibble        selected nibble
module psram_wr_buf
  import psram_pkg::*;
#(
  parameter int BURST_PIX = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [21:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_clear,
  input  logic [5:0]  i_rd_idx,
  output logic [4:0]  o_count,
  output logic [21:0] o_base,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_hit,
  output logic [3:0]  o_rd_nibble
);

  localparam int         BLK_BITS  = $clog2(BURST_PIX);
  localparam logic [4:0] BURST_CNT = 5'(BURST_PIX);

  logic [15:0] r_mem [MAX_BURST_PIX];
  logic [4:0]  r_count;
  logic [21:0] r_base;
  logic [21:0] w_next_addr;
  logic        w_same_block;
  logic [15:0] w_rd_pix;

  // The next pixel must be exactly base+count and must not leave the block;
  // 22-bit wrap from 3FFFFF to 0 changes the block bits, so it never hits.
  assign w_next_addr  = r_base + {17'd0, r_count};
  assign w_same_block = (w_next_addr >> BLK_BITS) == (r_base >> BLK_BITS);

  assign o_count = r_count;
  assign o_base  = r_base;
  assign o_full  = (r_count == BURST_CNT);
  assign o_empty = (r_count == 5'd0);
  assign o_hit   = o_empty || (!o_full && w_same_block && (i_wr_addr == w_next_addr));

  assign w_rd_pix = r_mem[i_rd_idx[5:2]];

  // Nibble select: pixels go out most significant nibble first
  always_comb begin
    o_rd_nibble = w_rd_pix[15:12];
    case (i_rd_idx[1:0])
      2'd0: o_rd_nibble = w_rd_pix[15:12];
      2'd1: o_rd_nibble = w_rd_pix[11:8];
      2'd2: o_rd_nibble = w_rd_pix[7:4];
      2'd3: o_rd_nibble = w_rd_pix[3:0];
      default: o_rd_nibble = w_rd_pix[15:12];
    endcase
  end

  // Pixel storage has no reset; stale slots are never read because the
  // burst length always comes from count
  always_ff @(posedge i_clk) begin
    if (i_wr_en && !i_clear) begin
      r_mem[r_count[3:0]] <= i_wr_data;
    end
  end

  // Count and base; the first pixel of a fresh buffer defines the base
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 5'd0;
      r_base  <= 22'd0;
    end else if (i_clear) begin
      r_count <= 5'd0;
    end else if (i_wr_en) begin
      if (r_count == 5'd0) begin
        r_base <= i_wr_addr;
      end
      r_count <= r_count + 5'd1;
    end
  end

endmodule

// File: rtl/psram_qpi_writer.sv
// QPI write engine for the 64 Mbit PSRAM frame buffer.
// Packs contiguous RGB565 pixels into bursts and writes them with the QPI
// Quad Write opcode once the shared SIO bus has been granted by the arbiter.
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_wr_valid/o_wr_ready  pixel handshake, i_wr_addr halfword address,
//                          i_wr_data RGB565 pixel
//   i_flush                pulse: write buffered pixels now
//   o_bus_req/i_bus_gnt    SIO bus arbitration with the reader
//   o_busy                 buffer non-empty or transaction in progress
//   o_PSRAM_CEn            chip enable, active low
//   o_psram_clk_en         enable for the gated PSRAM clock at top level
//   o_PSRAM_SIO_OUT        QPI nibble
//   o_PSRAM_SIO_DIR        1 = SIO driven by the FPGA
//   o_PSRAM_CMD_DIR        1 = command/address phase
module psram_qpi_writer
  import psram_pkg::*;
#(
  parameter int         BURST_PIX      = 16,
  parameter int         CS_HIGH_CYCLES = 3,
  parameter int         IDLE_FLUSH     = 64,
  parameter logic [7:0] CMD_WRITE      = QPI_CMD_WRITE
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_valid,
  output logic        o_wr_ready,
  input  logic [21:0] i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic        i_flush,
  output logic        o_bus_req,
  input  logic        i_bus_gnt,
  output logic        o_busy,
  output logic        o_PSRAM_CEn,
  output logic        o_psram_clk_en,
  output logic [3:0]  o_PSRAM_SIO_OUT,
  output logic        o_PSRAM_SIO_DIR,
  output logic        o_PSRAM_CMD_DIR
);

  localparam logic [4:0]  BURST_CNT = 5'(BURST_PIX);
  localparam logic [7:0]  CS_LAST   = 8'(CS_HIGH_CYCLES - 1);
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_FLUSH - 1);
  localparam logic [6:0]  CMD_LAST  = 7'(CMD_NIBBLES - 1);
  localparam logic [6:0]  ADDR_LAST = 7'(ADDR_NIBBLES - 1);

  psram_wr_state_t r_state;
  logic [6:0]  r_nib;
  logic [7:0]  r_cs;
  logic [15:0] r_idle;
  logic        r_bus_req;
  logic        r_cen;
  logic        r_clk_en;
  logic [3:0]  r_sio;
  logic        r_sio_dir;
  logic        r_cmd_dir;

  logic [4:0]  w_count;
  logic [21:0] w_base;
  logic        w_full;
  logic        w_empty;
  logic        w_hit;
  logic [3:0]  w_rd_nibble;
  logic        w_ready;
  logic        w_accept;
  logic [4:0]  w_count_next;
  logic        w_full_next;
  logic        w_mismatch;
  logic        w_timeout;
  logic        w_launch;
  logic        w_clear;
  logic [5:0]  w_rd_idx;
  logic [2:0]  w_addr_idx;
  logic [23:0] w_byte_addr;
  logic [3:0]  w_addr_nibble;
  logic [6:0]  w_data_last;

  // Outputs are taken straight from registers, so every nibble is computed
  // one cycle ahead, at the edge that enters its cycle
  psram_wr_buf #(
    .BURST_PIX (BURST_PIX)
  ) u_buf (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_wr_en     (w_accept),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_clear     (w_clear),
    .i_rd_idx    (w_rd_idx),
    .o_count     (w_count),
    .o_base      (w_base),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_hit       (w_hit),
    .o_rd_nibble (w_rd_nibble)
  );

  // A pixel that does not continue the current run sees wr_ready low and
  // triggers the launch in the same cycle; it is taken after the burst
  assign w_ready      = !i_reset && (r_state == ST_IDLE) && !w_full && w_hit;
  assign w_accept     = i_wr_valid && w_ready;
  assign w_count_next = w_count + {4'd0, w_accept};
  assign w_full_next  = (w_count_next == BURST_CNT);
  assign w_mismatch   = i_wr_valid && !w_empty && !w_hit;
  assign w_timeout    = (r_idle == IDLE_LAST) && !w_accept && !w_empty;
  assign w_launch     = (r_state == ST_IDLE) && (w_count_next != 5'd0) &&
                        (w_full_next || i_flush || w_timeout || w_mismatch);
  assign w_clear      = (r_state == ST_CSHI) && (r_cs == CS_LAST);

  assign w_data_last  = ({2'b00, w_count} * 7'(NIBBLES_PER_PIX)) - 7'd1;
  assign w_rd_idx     = (r_state == ST_DATA) ? (r_nib[5:0] + 6'd1) : 6'd0;
  assign w_addr_idx   = (r_state == ST_ADDR) ? (r_nib[2:0] + 3'd1) : 3'd0;
  assign w_byte_addr  = psram_byte_addr(w_base);

  // Address nibble for the upcoming ADDR cycle, MSB first
  always_comb begin
    w_addr_nibble = 4'h0;
    case (w_addr_idx)
      3'd0: w_addr_nibble = w_byte_addr[23:20];
      3'd1: w_addr_nibble = w_byte_addr[19:16];
      3'd2: w_addr_nibble = w_byte_addr[15:12];
      3'd3: w_addr_nibble = w_byte_addr[11:8];
      3'd4: w_addr_nibble = w_byte_addr[7:4];
      3'd5: w_addr_nibble = w_byte_addr[3:0];
      default: w_addr_nibble = 4'h0;
    endcase
  end

  // Main sequencer: collect, arbitrate, shift out command/address/data,
  // then hold CEn high and release the bus on the last recovery cycle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_nib     <= 7'd0;
      r_cs      <= 8'd0;
      r_idle    <= 16'd0;
      r_bus_req <= 1'b0;
      r_cen     <= 1'b1;
      r_clk_en  <= 1'b0;
      r_sio     <= 4'hF;
      r_sio_dir <= 1'b0;
      r_cmd_dir <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state   <= ST_REQ;
            r_bus_req <= 1'b1;
            r_idle    <= 16'd0;
          end else if (w_accept || w_empty) begin
            r_idle <= 16'd0;
          end else if (r_idle != IDLE_LAST) begin
            r_idle <= r_idle + 16'd1;
          end
        end
        ST_REQ: begin
          if (i_bus_gnt) begin
            r_state   <= ST_CMD;
            r_nib     <= 7'd0;
            r_cen     <= 1'b0;
            r_clk_en  <= 1'b1;
            r_sio_dir <= 1'b1;
            r_cmd_dir <= 1'b1;
            r_sio     <= CMD_WRITE[7:4];
          end
        end
        ST_CMD: begin
          if (r_nib == CMD_LAST) begin
            r_state <= ST_ADDR;
            r_nib   <= 7'd0;
            r_sio   <= w_addr_nibble;
          end else begin
            r_nib <= r_nib + 7'd1;
            r_sio <= CMD_WRITE[3:0];
          end
        end
        ST_ADDR: begin
          if (r_nib == ADDR_LAST) begin
            r_state   <= ST_DATA;
            r_nib     <= 7'd0;
            r_sio     <= w_rd_nibble;
            r_cmd_dir <= 1'b0;
          end else begin
            r_nib <= r_nib + 7'd1;
            r_sio <= w_addr_nibble;
          end
        end
        ST_DATA: begin
          if (r_nib == w_data_last) begin
            r_state   <= ST_CSHI;
            r_cs      <= 8'd0;
            r_cen     <= 1'b1;
            r_clk_en  <= 1'b0;
            r_sio     <= 4'hF;
            r_sio_dir <= 1'b0;
            r_cmd_dir <= 1'b0;
            r_bus_req <= (CS_HIGH_CYCLES > 1);
          end else begin
            r_nib <= r_nib + 7'd1;
            r_sio <= w_rd_nibble;
          end
        end
        ST_CSHI: begin
          if (r_cs == CS_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_cs <= r_cs + 8'd1;
            if ((r_cs + 8'd1) == CS_LAST) begin
              r_bus_req <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wr_ready      = w_ready;
  assign o_bus_req       = r_bus_req;
  assign o_busy          = (w_count != 5'd0) || (r_state != ST_IDLE);
  assign o_PSRAM_CEn     = r_cen;
  assign o_psram_clk_en  = r_clk_en;
  assign o_PSRAM_SIO_OUT = r_sio;
  assign o_PSRAM_SIO_DIR = r_sio_dir;
  assign o_PSRAM_CMD_DIR = r_cmd_dir;

endmodule

// File: tb/tb_psram_qpi_writer.sv
// Self-checking bench for psram_qpi_writer.
// Stimulus pushes the expected burst (byte address + pixels) into a queue;
// a monitor captures every CEn-low frame from the SIO bus and compares it
// against the head of that queue.
module tb_psram_qpi_writer;

  typedef struct packed {
    logic [23:0]  byteAddr;
    logic [4:0]   count;
    logic [255:0] pix;
  } burst_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        wrValid;
  logic        wrReady;
  logic [21:0] wrAddr;
  logic [15:0] wrData;
  logic        flush;
  logic        busReq;
  logic        busGnt;
  logic        busy;
  logic        cen;
  logic        clkEn;
  logic [3:0]  sio;
  logic        sioDir;
  logic        cmdDir;

  int checks = 0;
  int errors = 0;

  burst_t      expQ[$];
  logic [3:0]  capNib [80];
  logic        capCmd [80];
  logic        capDir [80];
  int          capN = 0;

  always #5 clk = ~clk;

  psram_qpi_writer dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_wr_valid      (wrValid),
    .o_wr_ready      (wrReady),
    .i_wr_addr       (wrAddr),
    .i_wr_data       (wrData),
    .i_flush         (flush),
    .o_bus_req       (busReq),
    .i_bus_gnt       (busGnt),
    .o_busy          (busy),
    .o_PSRAM_CEn     (cen),
    .o_psram_clk_en  (clkEn),
    .o_PSRAM_SIO_OUT (sio),
    .o_PSRAM_SIO_DIR (sioDir),
    .o_PSRAM_CMD_DIR (cmdDir)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushBurst(input logic [23:0] byteAddr, input int n, input logic [15:0] d0);
    burst_t b;
    b.byteAddr = byteAddr;
    b.count    = 5'(n);
    b.pix      = '0;
    for (int k = 0; k < n; k++) b.pix[k*16 +: 16] = d0 + 16'(k);
    expQ.push_back(b);
  endtask

  // Offer one pixel starting at posedge+1; returns at posedge+1 after it is taken
  task automatic applyStimulus(input logic [21:0] addr, input logic [15:0] data, output bit stalled);
    int waitCycles;
    waitCycles = 0;
    stalled = 1'b0;
    wrValid = 1'b1;
    wrAddr  = addr;
    wrData  = data;
    @(negedge clk);
    while (!wrReady && waitCycles < 500) begin
      stalled = 1'b1;
      waitCycles++;
      @(negedge clk);
    end
    checkOutput("acceptTimeout", {31'd0, wrReady}, 32'd1);
    @(posedge clk);
    #1;
    wrValid = 1'b0;
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  // Wait until the engine is idle and empty; report wr_ready leaks and the
  // recovery-phase shape (busy and bus_req seen after CEn rises)
  task automatic waitBurstDone(output int readyLeak, output int reqAfter, output int busyAfter);
    int cycles;
    bit seenLow;
    readyLeak = 0;
    reqAfter  = 0;
    busyAfter = 0;
    seenLow   = 1'b0;
    cycles    = 0;
    while (cycles < 1000) begin
      @(negedge clk);
      cycles++;
      if (!busy) break;
      if (wrReady) readyLeak++;
      if (!cen) seenLow = 1'b1;
      else if (seenLow) begin
        busyAfter++;
        if (busReq) reqAfter++;
      end
    end
    checkOutput("busyTimeout", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic compareBurst();
    burst_t      e;
    int          cmdCnt;
    int          dirCnt;
    int          lim;
    int          idx;
    logic [23:0] a;
    logic [15:0] p;
    if (expQ.size() == 0) begin
      checkOutput("unexpectedBurst", 32'(capN), 32'd0);
      return;
    end
    e = expQ.pop_front();
    checkOutput("burstLen", 32'(capN), 32'(8 + 4 * int'(e.count)));
    if (capN < 8) return;
    checkOutput("opcode", {24'd0, capNib[0], capNib[1]}, 32'h38);
    a = {capNib[2], capNib[3], capNib[4], capNib[5], capNib[6], capNib[7]};
    checkOutput("byteAddr", {8'd0, a}, {8'd0, e.byteAddr});
    lim = (capN < 80) ? capN : 80;
    cmdCnt = 0;
    dirCnt = 0;
    for (int i = 0; i < lim; i++) begin
      if (capCmd[i]) cmdCnt++;
      if (capDir[i]) dirCnt++;
    end
    checkOutput("cmdDirCycles", 32'(cmdCnt), 32'd8);
    checkOutput("sioDirCycles", 32'(dirCnt), 32'(lim));
    for (int k = 0; k < int'(e.count); k++) begin
      idx = 8 + 4 * k;
      if (idx + 3 < lim) p = {capNib[idx], capNib[idx+1], capNib[idx+2], capNib[idx+3]};
      else p = 16'hxxxx;
      checkOutput("pixel", {16'd0, p}, {16'd0, e.pix[k*16 +: 16]});
    end
  endtask

  // Monitor: collect SIO nibbles while CEn is low, compare when it rises.
  // A reset throws away a partially captured frame.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        capN = 0;
      end else if (!cen) begin
        if (capN < 80) begin
          capNib[capN] = sio;
          capCmd[capN] = cmdDir;
          capDir[capN] = sioDir;
        end
        capN++;
      end else if (capN > 0) begin
        compareBurst();
        capN = 0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stimulus
    bit stalled;
    int readyLeak;
    int reqAfter;
    int busyAfter;
    int n;
    int bad;

    reset   = 1'b1;
    wrValid = 1'b0;
    wrAddr  = '0;
    wrData  = '0;
    flush   = 1'b0;
    busGnt  = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstCEn",    {31'd0, cen},    32'd1);
    checkOutput("rstClkEn",  {31'd0, clkEn},  32'd0);
    checkOutput("rstSio",    {28'd0, sio},    32'hF);
    checkOutput("rstSioDir", {31'd0, sioDir}, 32'd0);
    checkOutput("rstCmdDir", {31'd0, cmdDir}, 32'd0);
    checkOutput("rstBusReq", {31'd0, busReq}, 32'd0);
    checkOutput("rstBusy",   {31'd0, busy},   32'd0);
    checkOutput("rstReady",  {31'd0, wrReady}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", {31'd0, wrReady}, 32'd1);
    @(posedge clk);
    #1;

    // Full 16-pixel burst at 0x100: byte address 0x000200
    $display("[TB] full burst");
    pushBurst(24'h000200, 16, 16'h1234);
    for (int k = 0; k < 16; k++) applyStimulus(22'h000100 + 22'(k), 16'h1234 + 16'(k), stalled);
    waitBurstDone(readyLeak, reqAfter, busyAfter);
    checkOutput("readyLowDuringBurst", 32'(readyLeak), 32'd0);
    checkOutput("cshiBusyCycles",      32'(busyAfter), 32'd3);
    checkOutput("cshiReqCycles",       32'(reqAfter),  32'd2);

    // Three pixels then idle: 64 idle cycles before the request
    $display("[TB] idle flush");
    pushBurst(24'h000040, 3, 16'hA000);
    for (int k = 0; k < 3; k++) applyStimulus(22'h000020 + 22'(k), 16'hA000 + 16'(k), stalled);
    n = 0;
    @(negedge clk);
    while (!busReq && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput("idleFlushDelay", 32'(n), 32'd64);
    waitBurstDone(readyLeak, reqAfter, busyAfter);
    checkOutput("idleCshiReq", 32'(reqAfter), 32'd2);

    // Address discontinuity: 0x40,0x41 then 0x80 stalls and starts a new block
    $display("[TB] discontinuity");
    pushBurst(24'h000080, 2, 16'hB000);
    pushBurst(24'h000100, 1, 16'hC000);
    applyStimulus(22'h000040, 16'hB000, stalled);
    checkOutput("firstNoStall", {31'd0, stalled}, 32'd0);
    applyStimulus(22'h000041, 16'hB001, stalled);
    applyStimulus(22'h000080, 16'hC000, stalled);
    checkOutput("gapStalled", {31'd0, stalled}, 32'd1);
    pulseFlush();
    waitBurstDone(readyLeak, reqAfter, busyAfter);

    // Block boundary: 0x0E,0x0F contiguous with 0x10 but 0x10 is a new block
    $display("[TB] block boundary");
    pushBurst(24'h00001C, 2, 16'hD000);
    pushBurst(24'h000020, 1, 16'hE000);
    applyStimulus(22'h00000E, 16'hD000, stalled);
    applyStimulus(22'h00000F, 16'hD001, stalled);
    applyStimulus(22'h000010, 16'hE000, stalled);
    checkOutput("blockStalled", {31'd0, stalled}, 32'd1);
    pulseFlush();
    waitBurstDone(readyLeak, reqAfter, busyAfter);

    // Flush with an empty buffer does nothing
    pulseFlush();
    @(negedge clk);
    checkOutput("emptyFlushBusy", {31'd0, busy},   32'd0);
    checkOutput("emptyFlushReq",  {31'd0, busReq}, 32'd0);
    @(posedge clk);
    #1;

    // Grant withheld for 50 cycles
    $display("[TB] grant delay");
    busGnt = 1'b0;
    pushBurst(24'h000600, 1, 16'h7777);
    applyStimulus(22'h000300, 16'h7777, stalled);
    pulseFlush();
    n = 0;
    while (!busReq && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("reqRaised", {31'd0, busReq}, 32'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cen || clkEn) bad++;
    end
    checkOutput("noGntQuiet", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    busGnt = 1'b1;
    @(negedge clk);
    checkOutput("gntSameCycleCEn", {31'd0, cen}, 32'd1);
    @(negedge clk);
    checkOutput("gntNextCycleCEn", {31'd0, cen}, 32'd0);
    waitBurstDone(readyLeak, reqAfter, busyAfter);

    // Reset in the middle of the data phase
    $display("[TB] reset mid-burst");
    for (int k = 0; k < 4; k++) applyStimulus(22'h000400 + 22'(k), 16'h9000 + 16'(k), stalled);
    pulseFlush();
    n = 0;
    @(negedge clk);
    while (cen && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput("abortBurstStarted", {31'd0, cen}, 32'd0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRstCEn",    {31'd0, cen},    32'd1);
    checkOutput("midRstClkEn",  {31'd0, clkEn},  32'd0);
    checkOutput("midRstBusReq", {31'd0, busReq}, 32'd0);
    checkOutput("midRstBusy",   {31'd0, busy},   32'd0);
    checkOutput("midRstDir",    {30'd0, sioDir, cmdDir}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midRstReady", {31'd0, wrReady}, 32'd1);
    @(posedge clk);
    #1;
    pushBurst(24'h000A00, 1, 16'h5A5A);
    applyStimulus(22'h000500, 16'h5A5A, stalled);
    pulseFlush();
    waitBurstDone(readyLeak, reqAfter, busyAfter);

    repeat (5) @(posedge clk);
    checkOutput("expQueueEmpty", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
